lcd_ctrl: RTL and testbench

LCD_CTRL -- requirements
Module: lcd_ctrl

---
 rtl/lcd_ctrl.sv | 90 +++++++++
 tb/tb_lcd_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: write-only character-LCD bus sequencer fed by a toggle-to-go register,
// with a one-deep pending slot and a sticky overflow flag.
module lcd_ctrl #(
  parameter int T_SETUP     = 4,
  parameter int T_EN        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 76000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_lcd_reg,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic [31:0] o_status
);
  localparam int CW = $clog2(T_EXEC_LONG) > 17 ? $clog2(T_EXEC_LONG) : 17;
  typedef enum logic [2:0] {IDLE, SETUP, EN_HI, HOLD, WAIT} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [7:0]    pend_data;
  logic          go_q, pend_valid, pend_rs, ovf, req, last, final_wait, mid, long_cmd, unused_bits;
  assign req         = i_lcd_reg[11] ^ go_q;
  assign last        = cnt == '0;
  assign final_wait  = state == WAIT && last;
  assign mid         = state != IDLE && !final_wait;
  assign long_cmd    = !o_lcd_rs && (o_lcd_data inside {8'h01, 8'h02, 8'h03});
  assign o_lcd_rw    = 1'b0;
  assign o_status    = {29'b0, ovf, pend_valid, (state != IDLE) | pend_valid};
  assign unused_bits = ^{i_lcd_reg[29:12], i_lcd_reg[10], i_lcd_reg[8]};
  // A request landing on the final WAIT cycle never overflows: the pending slot drains that same edge.
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state      <= IDLE;
      cnt        <= '0;
      go_q       <= 1'b0;
      pend_valid <= 1'b0;
      pend_rs    <= 1'b0;
      pend_data  <= '0;
      ovf        <= 1'b0;
      o_lcd_data <= '0;
      o_lcd_rs   <= 1'b0;
      o_lcd_en   <= 1'b0;
      o_lcd_on   <= 1'b0;
    end else begin
      go_q       <= i_lcd_reg[11];
      o_lcd_on   <= i_lcd_reg[31];
      ovf        <= (req && pend_valid && mid) ? 1'b1 : i_lcd_reg[30] ? 1'b0 : ovf;
      pend_valid <= final_wait ? pend_valid & req : mid ? pend_valid | req : pend_valid;
      if (req && (final_wait || !pend_valid)) begin
        pend_rs   <= i_lcd_reg[9];
        pend_data <= i_lcd_reg[7:0];
      end
      if (!last) cnt <= cnt - 1'b1;
      case (state)
        IDLE: if (req) begin
          state      <= SETUP;
          cnt        <= CW'(T_SETUP - 1);
          o_lcd_rs   <= i_lcd_reg[9];
          o_lcd_data <= i_lcd_reg[7:0];
        end
        SETUP: if (last) begin
          state    <= EN_HI;
          cnt      <= CW'(T_EN - 1);
          o_lcd_en <= 1'b1;
        end
        EN_HI: if (last) begin
          state    <= HOLD;
          cnt      <= CW'(T_HOLD - 1);
          o_lcd_en <= 1'b0;
        end
        HOLD: if (last) begin
          state <= WAIT;
          cnt   <= long_cmd ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
        end
        WAIT: if (last) begin
          state <= (pend_valid || req) ? SETUP : IDLE;
          cnt   <= (pend_valid || req) ? CW'(T_SETUP - 1) : '0;
          if (pend_valid || req) begin
            o_lcd_rs   <= pend_valid ? pend_rs : i_lcd_reg[9];
            o_lcd_data <= pend_valid ? pend_data : i_lcd_reg[7:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: randomized scoreboard bench; a transaction-level model predicts bus pulses and status.
module tb_lcd_ctrl;
  localparam int TS = 3, TE = 5, TH = 2, TX = 10, TL = 40;
  localparam logic [31:0] USED = 32'hC000_0AFF;
  logic        clk = 0, i_reset = 1;
  logic [31:0] i_lcd_reg = 0;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
  logic [31:0] o_status;
  lcd_ctrl #(.T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TL)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_lcd_reg(i_lcd_reg), .o_lcd_data(o_lcd_data),
    .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_en(o_lcd_en), .o_lcd_on(o_lcd_on),
    .o_status(o_status));
  always #5 clk = ~clk;

  typedef struct {int rise; logic rs; logic [7:0] data;} xfer_t;
  xfer_t      exp_q[$];
  logic [3:0] st_q[$];
  int vectors = 0, miscompares = 0, cyc = 0;
  bit mon_en = 0, on_b = 1, go_b = 0;
  // model: one active command ending at act_end, optional pending command
  bit act = 0, pv = 0, ovf_m = 0, go_prev = 0, on_exp = 0;
  int act_end = 0;
  logic pr;
  logic [7:0] pd;

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, a, e, cyc);
    end
  endtask

  function automatic int dur(logic rs, logic [7:0] d);
    return TS + TE + TH + ((!rs && d >= 8'h01 && d <= 8'h03) ? TL : TX);
  endfunction

  task automatic start(int s, logic rs, logic [7:0] d);
    exp_q.push_back(xfer_t'{s + TS, rs, d});
    act = 1;
    act_end = s + dur(rs, d) - 1;
  endtask

  task automatic advance(int c);
    while (act && act_end < c) begin
      if (pv) begin pv = 0; start(act_end + 1, pr, pd); end
      else act = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    advance(cyc);
    st_q.push_back({on_exp, ovf_m, pv, act});
  endtask

  task automatic drive(input logic on, input logic clr, input logic go, input logic rs, input logic [7:0] d);
    bit set = 0;
    i_lcd_reg = ($urandom & ~USED) | {on, clr, 18'b0, go, 1'b0, rs, 1'b0, d};
    if (go != go_prev) begin
      if (act && act_end == cyc) advance(cyc + 1);
      if (!act) start(cyc + 1, rs, d);
      else if (!pv) begin pv = 1; pr = rs; pd = d; end
      else set = 1;
    end
    go_prev = go;
    on_exp = on;
    ovf_m = set ? 1'b1 : clr ? 1'b0 : ovf_m;
    tick();
  endtask

  task automatic hold(int n);
    repeat (n) drive(on_b, 1'b0, go_b, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d);
    go_b = ~go_b;
    drive(on_b, 1'b0, go_b, rs, d);
  endtask

  task automatic wait_en();
    int n = 0;
    while (!o_lcd_en && n < 50) begin hold(1); n++; end
    chk("en_wait", o_lcd_en, 1);
  endtask

  task automatic do_reset(input logic [31:0] v, input int n);
    mon_en = 0;
    i_reset = 0;
    i_lcd_reg = v;
    #1;
    chk("async_rst", {o_lcd_en, o_status}, 0);
    act = 0; pv = 0; ovf_m = 0; go_prev = 0; on_exp = 0;
    exp_q.delete();
    st_q.delete();
    repeat (n) @(posedge clk);
    #1;
    chk("rst_outs", {o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_status}, 0);
    i_reset = 1;
    cyc++;
    st_q.push_back(4'h0);
    mon_en = 1;
  endtask

  initial begin
    xfer_t cur;
    int rise_c = 0;
    bit prev_en = 0;
    logic [3:0] e;
    forever begin
      @(negedge clk);
      if (!mon_en) prev_en = 0;
      else begin
        if (st_q.size() != 0) begin
          e = st_q.pop_front();
          chk("status", {o_lcd_rw, o_lcd_on, o_status}, {1'b0, e[3], 29'b0, e[2:0]});
        end
        if (o_lcd_en && !prev_en) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pulse: rs=%0b data=%0h at cycle %0d, expected no pulse", o_lcd_rs, o_lcd_data, cyc);
          end else begin
            cur = exp_q.pop_front();
            rise_c = cyc;
            chk("rise_cycle", cyc, cur.rise);
            chk("bus", {o_lcd_rs, o_lcd_data}, {cur.rs, cur.data});
          end
        end
        if (!o_lcd_en && prev_en) begin
          chk("en_width", cyc - rise_c, TE);
          chk("bus_hold", {o_lcd_rs, o_lcd_data}, {cur.rs, cur.data});
        end
        prev_en = o_lcd_en;
      end
    end
  end

  initial begin
    int n;
    logic [7:0] d;
    #3;
    do_reset(32'h0, 2);
    wr(1'b0, 8'h41);
    hold(TS + TE + TH + TX + 3);
    wr(1'b0, 8'h01);
    hold(3);
    wr(1'b1, 8'h01);
    hold(80);
    wr(1'b0, 8'h30);
    wait_en();
    wr(1'b1, 8'h42);
    hold(60);
    wr(1'b1, 8'hA0);
    wr(1'b1, 8'hA1);
    hold(2);
    wr(1'b1, 8'hA2);
    hold(2);
    drive(on_b, 1'b1, go_b, 1'b0, 8'h00);
    hold(60);
    wr(1'b1, 8'h50);
    while (cyc < act_end) hold(1);
    wr(1'b1, 8'h51);
    hold(60);
    wr(1'b0, 8'h60);
    wr(1'b0, 8'h61);
    while (cyc < act_end) hold(1);
    wr(1'b0, 8'h62);
    hold(90);
    for (int i = 0; i < 250; i++) begin
      hold($urandom_range(0, 25));
      n = $urandom_range(0, 9);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      if (n == 0) drive(on_b, 1'b1, go_b, 1'b0, 8'h00);
      else if (n == 1) on_b = ~on_b;
      else wr(1'($urandom_range(0, 1)), d);
    end
    hold(100);
    on_b = 1;
    wr(1'b0, 8'h77);
    wr(1'b1, 8'h78);
    wait_en();
    go_b = 0;
    do_reset(32'h8000_0000, 3);
    hold(40);
    go_b = 1;
    do_reset(32'h8000_0800, 2);
    drive(on_b, 1'b0, go_b, 1'b0, 8'h55);
    hold(40);
    n = 0;
    while ((act || pv) && n < 500) begin hold(1); n++; end
    hold(3);
    chk("drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
